neander_seq_divider: RTL and testbench

Sequential restoring divider for the NEANDER-X CPU. It produces the quotient, remainder and divide-by-zero flag that the ALU consumes for DIV and MOD. The control unit pulses start with the operands and waits for done, at which point the ALU selects the results. It resolves one quotient bit per cycle, trading area for 8-cycle latency against a combinational divider.

---
 rtl/neander_x_pkg.sv | 13 +
 rtl/neander_seq_divider.sv | 112 +++++++++++
 tb/tb_neander_seq_divider.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/neander_x_pkg.sv
// Shared NEANDER-X definitions: divider FSM states and sizing constants.
package neander_x_pkg;

   typedef enum logic [1:0] {
      DIV_IDLE,
      DIV_RUN,
      DIV_DONE
   } div_state_t;

   localparam int DIV_WIDTH = 8;
   localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

endpackage

// File: rtl/neander_seq_divider.sv
// Sequential restoring divider for the NEANDER-X ALU (DIV/MOD), one quotient bit per cycle.
// Build option NEANDER_DIV_FAST_ZERO_EN: a zero divisor completes immediately instead of iterating.
module neander_seq_divider
   import neander_x_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] div_quotient,
   output logic [WIDTH-1:0] div_remainder,
   output logic             div_by_zero
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   div_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH:0]   rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] dsr_q;

   logic             accept;
   logic             last_iter;
   logic             fast_zero;
   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] trial;
   logic [WIDTH:0]   rem_nxt;
   logic [WIDTH-1:0] quo_nxt;

   // One restoring step; the partial remainder stays below the divisor, so the top bit of shifted is 0
   // and the sign of trial tells whether the subtraction fits.
   always_comb begin
      shifted = {rem_q, quo_q[WIDTH-1]};
      trial   = shifted - {2'b00, dsr_q};
      if (trial[WIDTH+1]) begin
         rem_nxt = shifted[WIDTH:0];
         quo_nxt = {quo_q[WIDTH-2:0], 1'b0};
      end else begin
         rem_nxt = trial[WIDTH:0];
         quo_nxt = {quo_q[WIDTH-2:0], 1'b1};
      end
   end

   always_comb begin
      accept    = start && (state_q == DIV_IDLE || state_q == DIV_DONE);
      last_iter = (cnt_q == CNT_W'(WIDTH - 1));
`ifdef NEANDER_DIV_FAST_ZERO_EN
      fast_zero = accept && (divisor == '0);
`else
      fast_zero = 1'b0;
`endif
      state_d = state_q;
      case (state_q)
         DIV_IDLE, DIV_DONE: begin
            if (accept) state_d = fast_zero ? DIV_DONE : DIV_RUN;
            else        state_d = DIV_IDLE;
         end
         DIV_RUN: if (last_iter) state_d = DIV_DONE;
         default: state_d = DIV_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= DIV_IDLE;
      else       state_q <= state_d;
   end

   // Iteration counter and architecturally visible results
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q         <= '0;
         div_quotient  <= '0;
         div_remainder <= '0;
         div_by_zero   <= 1'b0;
      end else if (accept) begin
         cnt_q       <= '0;
         div_by_zero <= (divisor == '0);
         if (fast_zero) begin
            div_quotient  <= '1;
            div_remainder <= dividend;
         end
      end else if (state_q == DIV_RUN) begin
         cnt_q <= cnt_q + 1'b1;
         if (last_iter) begin
            div_quotient  <= quo_nxt;
            div_remainder <= rem_nxt[WIDTH-1:0];
         end
      end
   end

   // Working registers are fully reloaded on every accepted start, so they need no reset
   always_ff @(posedge clk) begin
      if (accept) begin
         quo_q <= dividend;
         dsr_q <= divisor;
         rem_q <= '0;
      end else if (state_q == DIV_RUN) begin
         quo_q <= quo_nxt;
         rem_q <= rem_nxt;
      end
   end

   assign busy = (state_q == DIV_RUN);
   assign done = (state_q == DIV_DONE);

endmodule

// File: tb/tb_neander_seq_divider.sv
// Randomized self-checking bench for neander_seq_divider against a plain / and % reference model.
module tb_neander_seq_divider;

   localparam int W = 8;
`ifdef NEANDER_DIV_FAST_ZERO_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] div_quotient;
   logic [W-1:0] div_remainder;
   logic         div_by_zero;

   int n_checks = 0;
   int n_errors = 0;

   neander_seq_divider #(.WIDTH(W)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .dividend     (dividend),
      .divisor      (divisor),
      .busy         (busy),
      .done         (done),
      .div_quotient (div_quotient),
      .div_remainder(div_remainder),
      .div_by_zero  (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] q, output logic [W-1:0] r);
      if (b == 0) begin
         q = '1;
         r = a;
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   // Called at a negedge; returns at the negedge following the accepting edge.
   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // lat counts clock edges after the accepting edge until done is seen.
   task automatic wait_done(output int lat, output int bcnt);
      lat  = 0;
      bcnt = 0;
      while (!done && lat < 40) begin
         if (busy) bcnt++;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                               input int lat, input int bcnt);
      logic [W-1:0] eq, er;
      int           elat;
      ref_div(a, b, eq, er);
      elat = (b == 0 && FAST) ? 0 : W;
      check({tag, "_lat"}, lat, elat);
      check({tag, "_busy"}, bcnt, elat);
      check({tag, "_done"}, done, 1'b1);
      check({tag, "_q"}, div_quotient, eq);
      check({tag, "_r"}, div_remainder, er);
      check({tag, "_dbz"}, div_by_zero, (b == 0));
   endtask

   task automatic do_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
      int lat, bcnt;
      launch(a, b);
      wait_done(lat, bcnt);
      check_result(tag, a, b, lat, bcnt);
   endtask

   initial begin
      int lat, bcnt, gap;
      logic [W-1:0] a, b, eq, er;
      bit saw_done;

      reset    = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_q", div_quotient, 0);
      check("rst_r", div_remainder, 0);
      check("rst_dbz", div_by_zero, 0);
      reset = 1'b0;
      @(negedge clk);

      do_div("d200_7", 8'hC8, 8'h07);
      @(negedge clk);
      check("done_pulse", done, 0);
      check("idle_busy", busy, 0);

      // back-to-back: second start issued during the DONE cycle
      do_div("d255_1", 8'hFF, 8'h01);
      do_div("d3_10", 8'h03, 8'h0A);
      @(negedge clk);

      do_div("d5_0", 8'h05, 8'h00);
      @(negedge clk);

      // start held through RUN with operands changed mid-flight
      dividend = 8'd100;
      divisor  = 8'd9;
      start    = 1'b1;
      @(negedge clk);
      repeat (3) @(negedge clk);
      dividend = 8'h10;
      divisor  = 8'h02;
      repeat (4) @(negedge clk);
      start = 1'b0;
      wait_done(lat, bcnt);
      check("hold_lat", lat + 7, W);
      check("hold_q", div_quotient, 8'h0B);
      check("hold_r", div_remainder, 8'h01);
      @(negedge clk);

      // reset aborts a divide in progress
      launch(8'hC8, 8'h07);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_q", div_quotient, 0);
      check("abort_r", div_remainder, 0);
      check("abort_dbz", div_by_zero, 0);
      saw_done = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      check("abort_no_done", saw_done, 0);
      do_div("d64_8", 8'h40, 8'h08);
      @(negedge clk);

      do_div("d0_1", 8'h00, 8'h01);
      do_div("d255_255", 8'hFF, 8'hFF);
      do_div("d1_255", 8'h01, 8'hFF);
      do_div("d128_3", 8'h80, 8'h03);
      @(negedge clk);

      // randomized runs with random idle gaps (gap 0 chains in the DONE cycle)
      repeat (1500) begin
         a = W'($urandom);
         b = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
         launch(a, b);
         wait_done(lat, bcnt);
         check_result("rand", a, b, lat, bcnt);
         ref_div(a, b, eq, er);
         gap = $urandom_range(0, 3);
         repeat (gap) begin
            @(negedge clk);
            check("hold_done", done, 0);
            check("hold_q", div_quotient, eq);
            check("hold_r", div_remainder, er);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
